ex_mem_stage_elastic: RTL and testbench
=======================================

Name: ex_mem_stage_elastic

Overview:
- Parametrised, elastic EX→MEM pipeline stage for the five-stage core. Replaces the fixed, always-advancing EX/MEM register.
- Adds:
  - valid/ready handshaking, so MEM back-pressure stalls EX without losing data;
  - a 2-entry skid buffer, so ready is registered;
  - a synchronous flush that inserts bubbles;
  - an asynchronous active-low reset.
- Sits between the ALU/forwarding logic and the data-memory interface. Also drives the MEM-stage forwarding outputs for the hazard unit.

Parameters:
DATA_W, 32, width of ALU result and store-data fields
REG_W, 5, width of destination register index
CTRL_W, 4, control bundle width; bit order {RegWrite, MemWrite, MemtoReg, MemRead}, bit 0 = MemRead

Ports:
clk  input  1  stage clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous flush; empties stage and discards any concurrent input beat
in_valid  input  1  EX presents a valid instruction
in_ready  output  1  stage can accept a beat (registered)
in_ctrl  input  CTRL_W  EX control bundle
in_alu_result  input  DATA_W  ALU result / memory address
in_write_data  input  DATA_W  store data
in_reg_dst  input  REG_W  destination register index
out_valid  output  1  MEM-side beat valid
out_ready  input  1  MEM consumes beat
out_ctrl  output  CTRL_W  control bundle; forced 0 when out_valid=0
out_alu_result  output  DATA_W  registered ALU result
out_write_data  output  DATA_W  registered store data
out_reg_dst  output  REG_W  registered destination index
fwd_reg_write  output  1  out_valid & out_ctrl[3]; combinational
fwd_reg_dst  output  REG_W  out_reg_dst; combinational
occupancy  output  2  entries held: 0, 1 or 2

Behaviour:
- Storage:
  - main register M, drives the outputs;
  - skid register S, each entry with its own valid bit.
- Transfers:
  - input transfer = in_valid & in_ready;
  - output transfer = out_valid & out_ready.
- in_ready is registered:
  - equals !S.valid;
  - reset value 1.
- Reset (rst_n=0, asynchronous):
  - M.valid=0, S.valid=0, in_ready=1, occupancy=0;
  - all data/ctrl/reg_dst registers cleared to 0.
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle), provided M is empty or drains at edge N.
- Per-edge update, flush=0:
  - M empty or draining, S empty: an input transfer loads M; otherwise M.valid←0.
  - M empty or draining, S full: S moves to M, S.valid←0. No input transfer is possible (in_ready=0).
  - M full and not draining, input transfer: the beat is captured in S, S.valid←1.
  - M full and not draining, no input transfer: hold.
- Ordering: strict FIFO order is guaranteed. An S entry always reaches M before any newer beat.
- flush=1 at an edge:
  - M.valid←0, S.valid←0;
  - any concurrent input beat is dropped;
  - any output transfer in that cycle still completes on the MEM side;
  - in_ready←1 on the next cycle.
  - Flush has priority over every transfer.
  - Data fields are not cleared by flush; out_ctrl reads 0 because out_valid=0.
- Bubble rule: out_ctrl = M.ctrl when M.valid, else 0. Idle stages therefore never assert MemWrite or RegWrite.
- Occupancy: occupancy = M.valid + S.valid.
- Overflow is impossible, because in_ready is low whenever S is full.
- Reset mid-operation: all entries are discarded immediately; outputs go to reset values without waiting for clk.
- Handshake requirement on EX: in_* must be held stable while in_valid=1 and in_ready=0.

Test Plan:
- Reset: hold rst_n=0 with in_valid=1 and clock running → out_valid=0, out_ctrl=0, in_ready=1, occupancy=0. Release rst_n → first beat {ctrl=4'b1000, alu=0x10, wd=0, dst=5} appears one cycle later.
- Streaming: out_ready=1, 8 back-to-back beats with alu=0..7 → outputs alu=0..7 on consecutive cycles, 1-cycle latency, in_ready stays 1, occupancy≤1.
- Back-pressure: out_ready=0, send A(alu=0xA) then B(alu=0xB) → occupancy=2, in_ready=0, B held. Raise out_ready → A then B, in order, no duplication; in_ready returns 1 one cycle after S drains.
- Flush with full stage: occupancy=2, assert flush with in_valid=1 and C(alu=0xC) → next cycle out_valid=0, out_ctrl=0, occupancy=0, in_ready=1; C never appears.
- Forwarding: beat ctrl=4'b1000, dst=7 in M → fwd_reg_write=1, fwd_reg_dst=7. Beat ctrl=4'b0100 (store) → fwd_reg_write=0. Empty stage → fwd_reg_write=0.
- Async reset mid-stall: occupancy=2, pull rst_n low between edges → out_valid, occupancy and out_alu_result go to 0 before the next clk edge.

Source files
------------

// File: rtl/ex_mem_stage_elastic.sv
// ---------------------------------------------------------------------------
// ex_mem_stage_elastic
//
// Elastic EX->MEM pipeline register with valid/ready handshaking. A main
// register (M) drives the MEM side. A one-entry skid register (S) absorbs the
// beat that EX may still present in the cycle in which MEM stalls, so in_ready
// can come straight from a flop. A synchronous flush empties both entries and
// drops any concurrent input beat. An asynchronous active-low reset clears all
// state.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   flush                   synchronous flush, higher priority than any transfer
//   in_valid / in_ready     EX-side handshake (in_ready is registered)
//   in_ctrl, in_alu_result,
//   in_write_data,
//   in_reg_dst              EX-side payload
//   out_valid / out_ready   MEM-side handshake
//   out_ctrl, out_alu_result,
//   out_write_data,
//   out_reg_dst             MEM-side payload (out_ctrl is 0 when out_valid=0)
//   fwd_reg_write,
//   fwd_reg_dst             MEM-stage forwarding information for the hazard unit
//   occupancy               number of entries held (0..2)
// ---------------------------------------------------------------------------
module ex_mem_stage_elastic #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CTRL_W = 4   // {RegWrite, MemWrite, MemtoReg, MemRead}
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_write_data,
  input  logic [REG_W-1:0]  in_reg_dst,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_write_data,
  output logic [REG_W-1:0]  out_reg_dst,
  output logic              fwd_reg_write,
  output logic [REG_W-1:0]  fwd_reg_dst,
  output logic [1:0]        occupancy
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] write_data;
    logic [REG_W-1:0]  reg_dst;
  } beat_t;

  beat_t m_q, m_d, s_q, s_d, in_beat;
  logic  m_valid_q, m_valid_d;
  logic  s_valid_q, s_valid_d;
  logic  in_ready_q;

  logic  in_xfer;
  logic  m_free;   // M is empty or hands its beat to MEM at this edge

  assign in_beat = '{ctrl:       in_ctrl,
                     alu_result: in_alu_result,
                     write_data: in_write_data,
                     reg_dst:    in_reg_dst};

  assign in_xfer = in_valid & in_ready_q;
  assign m_free  = ~m_valid_q | out_ready;

  always_comb begin
    // NOTE: every signal assigned here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    m_d       = m_q;
    s_d       = s_q;
    m_valid_d = m_valid_q;
    s_valid_d = s_valid_q;

    if (flush) begin
      // Payload fields are left as they are; out_ctrl is masked by out_valid.
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
    end else if (m_free) begin
      if (s_valid_q) begin
        // Older skid entry goes first; in_ready is low so no new beat arrives.
        m_d       = s_q;
        m_valid_d = 1'b1;
        s_valid_d = 1'b0;
      end else if (in_xfer) begin
        m_d       = in_beat;
        m_valid_d = 1'b1;
      end else begin
        m_valid_d = 1'b0;
      end
    end else if (in_xfer) begin
      // M is stalled: park the beat that arrived in the stall cycle.
      s_d       = in_beat;
      s_valid_d = 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: payload registers are reset as well as the valid bits, so the
      // outputs show known zeros straight out of reset.
      m_q        <= '0;
      s_q        <= '0;
      m_valid_q  <= 1'b0;
      s_valid_q  <= 1'b0;
      in_ready_q <= 1'b1;
    end else begin
      m_q        <= m_d;
      s_q        <= s_d;
      m_valid_q  <= m_valid_d;
      s_valid_q  <= s_valid_d;
      in_ready_q <= ~s_valid_d;
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = m_valid_q;
  assign out_ctrl       = m_valid_q ? m_q.ctrl : '0;
  assign out_alu_result = m_q.alu_result;
  assign out_write_data = m_q.write_data;
  assign out_reg_dst    = m_q.reg_dst;

  assign fwd_reg_write  = m_valid_q & m_q.ctrl[CTRL_W-1];
  assign fwd_reg_dst    = m_q.reg_dst;

  assign occupancy      = {1'b0, m_valid_q} + {1'b0, s_valid_q};

endmodule

// File: tb/tb_ex_mem_stage_elastic.sv
// ---------------------------------------------------------------------------
// tb_ex_mem_stage_elastic
//
// Directed bench for ex_mem_stage_elastic. A FIFO scoreboard holds the beats
// the stage should currently contain: beats are pushed when an input transfer
// is expected, popped when an output transfer is expected, and cleared on
// flush or reset. The head of the queue is the expected MEM-side beat.
// ---------------------------------------------------------------------------
module tb_ex_mem_stage_elastic;

  localparam int DATA_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 4;

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] wd;
    logic [REG_W-1:0]  dst;
  } beat_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_alu_result;
  logic [DATA_W-1:0] in_write_data;
  logic [REG_W-1:0]  in_reg_dst;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_alu_result;
  logic [DATA_W-1:0] out_write_data;
  logic [REG_W-1:0]  out_reg_dst;
  logic              fwd_reg_write;
  logic [REG_W-1:0]  fwd_reg_dst;
  logic [1:0]        occupancy;

  int    total = 0;
  int    bad   = 0;
  beat_t sb[$];

  ex_mem_stage_elastic #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_ctrl       (in_ctrl),
    .in_alu_result (in_alu_result),
    .in_write_data (in_write_data),
    .in_reg_dst    (in_reg_dst),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_ctrl      (out_ctrl),
    .out_alu_result(out_alu_result),
    .out_write_data(out_write_data),
    .out_reg_dst   (out_reg_dst),
    .fwd_reg_write (fwd_reg_write),
    .fwd_reg_dst   (fwd_reg_dst),
    .occupancy     (occupancy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [3:0] c, input logic [31:0] a,
                       input logic [31:0] w, input logic [4:0] d);
    in_valid      = v;
    in_ctrl       = c;
    in_alu_result = a;
    in_write_data = w;
    in_reg_dst    = d;
  endtask

  // Compare the DUT state against the scoreboard just before the next rising
  // edge, then update the scoreboard for that edge and step past it.
  task automatic step(input string tag);
    beat_t head;
    int    n;
    bit    accept;
    @(negedge clk);
    n = sb.size();
    check({tag, ".occupancy"}, 64'(occupancy), 64'(n));
    check({tag, ".in_ready"},  64'(in_ready),  64'(n < 2));
    check({tag, ".out_valid"}, 64'(out_valid), 64'(n > 0));
    if (n > 0) begin
      head = sb[0];
      check({tag, ".out_ctrl"}, 64'(out_ctrl),       64'(head.ctrl));
      check({tag, ".out_alu"},  64'(out_alu_result), 64'(head.alu));
      check({tag, ".out_wd"},   64'(out_write_data), 64'(head.wd));
      check({tag, ".out_dst"},  64'(out_reg_dst),    64'(head.dst));
      check({tag, ".fwd_we"},   64'(fwd_reg_write),  64'(head.ctrl[3]));
      check({tag, ".fwd_dst"},  64'(fwd_reg_dst),    64'(head.dst));
    end else begin
      check({tag, ".out_ctrl_bubble"}, 64'(out_ctrl),      64'(0));
      check({tag, ".fwd_we_bubble"},   64'(fwd_reg_write), 64'(0));
    end
    accept = in_valid && (n < 2) && !flush;
    if (n > 0 && out_ready) void'(sb.pop_front());
    if (flush) sb.delete();
    else if (accept) sb.push_back('{ctrl: in_ctrl, alu: in_alu_result,
                                    wd: in_write_data, dst: in_reg_dst});
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n     = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 4'b1000, 32'h10, 32'h0, 5'd5);

    // Reset held with in_valid high and the clock running.
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.out_ctrl",  64'(out_ctrl),  64'(0));
    check("rst.in_ready",  64'(in_ready),  64'(1));
    check("rst.occupancy", 64'(occupancy), 64'(0));
    check("rst.out_alu",   64'(out_alu_result), 64'(0));

    // First beat after reset release appears one cycle later.
    rst_n = 1'b1;
    step("first_in");
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("first_out");
    step("first_idle");

    // Streaming: eight back-to-back beats with MEM always ready.
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 4'b1000, 32'(i), 32'(i * 3 + 1), 5'(i + 1));
      step($sformatf("stream%0d", i));
    end
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("stream_tail");
    step("stream_idle");

    // Back-pressure: A then B fill M and S, then drain in order.
    out_ready = 1'b0;
    drive(1'b1, 4'b0001, 32'hA, 32'h1A, 5'd10);
    step("bp_a");
    drive(1'b1, 4'b1001, 32'hB, 32'h1B, 5'd11);
    step("bp_b");
    step("bp_full");          // B held stable, in_ready low, nothing accepted
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("bp_hold");
    out_ready = 1'b1;
    step("bp_drain_a");
    step("bp_drain_b");
    step("bp_empty");

    // Flush with a full stage and a concurrent beat C that must be dropped.
    out_ready = 1'b0;
    drive(1'b1, 4'b0100, 32'h21, 32'h31, 5'd3);
    step("fl_fill1");
    drive(1'b1, 4'b1000, 32'h22, 32'h32, 5'd4);
    step("fl_fill2");
    drive(1'b1, 4'b1000, 32'hC, 32'hCC, 5'd12);
    flush = 1'b1;
    step("fl_flush");
    flush = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    out_ready = 1'b1;
    step("fl_after");
    step("fl_after2");

    // Flush while M hands a beat to MEM in the same cycle.
    drive(1'b1, 4'b1010, 32'h40, 32'h41, 5'd20);
    step("fl2_fill");
    drive(1'b1, 4'b1000, 32'h50, 32'h51, 5'd21);
    flush = 1'b1;
    step("fl2_flush");
    flush = 1'b0;
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("fl2_after");

    // Forwarding: register-writing beat, then a store, then empty.
    out_ready = 1'b0;
    drive(1'b1, 4'b1000, 32'h77, 32'h0, 5'd7);
    step("fwd_load");
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("fwd_hold");
    out_ready = 1'b1;
    drive(1'b1, 4'b0100, 32'h88, 32'h99, 5'd9);
    step("fwd_store_in");
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("fwd_store_out");
    step("fwd_empty");

    // Asynchronous reset while the stage is full and stalled.
    out_ready = 1'b0;
    drive(1'b1, 4'b1000, 32'hD1, 32'hE1, 5'd13);
    step("ar_fill1");
    drive(1'b1, 4'b1000, 32'hD2, 32'hE2, 5'd14);
    step("ar_fill2");
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("ar_full");
    #2 rst_n = 1'b0;
    #1;
    check("ar.out_valid", 64'(out_valid),      64'(0));
    check("ar.occupancy", 64'(occupancy),      64'(0));
    check("ar.out_alu",   64'(out_alu_result), 64'(0));
    check("ar.in_ready",  64'(in_ready),       64'(1));
    check("ar.out_ctrl",  64'(out_ctrl),       64'(0));
    sb.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    drive(1'b1, 4'b1001, 32'hF0, 32'hF1, 5'd15);
    step("ar_resume_in");
    drive(1'b0, 4'b0, 32'h0, 32'h0, 5'd0);
    step("ar_resume_out");
    step("ar_resume_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
